// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch-to-decode queue: thread id, queued entry and the
// 4-way head selector used by the decode-side output mux.
package fetch_queue_pkg;

  localparam int WIDTH    = 32;
  localparam int THREADS  = 4;
  localparam int FQ_DEPTH = 2;

  typedef logic [1:0] tid_t;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
  } fq_entry_t;

  function automatic fq_entry_t mux4(input fq_entry_t d0, input fq_entry_t d1,
                                     input fq_entry_t d2, input fq_entry_t d3,
                                     input tid_t sel);
    case (sel)
      2'd0:    return d0;
      2'd1:    return d1;
      2'd2:    return d2;
      default: return d3;
    endcase
  endfunction

endpackage

// File: rtl/fetch_queue_thread_fifo.sv
// Per-thread instruction FIFO. Flush empties it in one cycle and wins over
// push/pop; the head reads as zero while the FIFO is empty.
module thread_fifo
  import fetch_queue_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  fq_entry_t     i_data,
  output logic [CW-1:0] o_count,
  output fq_entry_t     o_head
);

  fq_entry_t     r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_count <= '0;
      r_rd    <= r_wr;
    end else begin
      // The upstream stall keeps this from ever firing on a full FIFO.
      if (i_push) assert (r_count < CW'(DEPTH));
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = (r_count != '0) ? r_mem[r_rd] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode stage: F1 issues the imem read, F2 catches the returned word
// and pushes it into the owning thread's FIFO; decode pops by thread id.
module fetch_queue
  import fetch_queue_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   PCF,
  input  tid_t               TID_fetch,
  input  logic               EXE_BR_TAKEN,
  input  tid_t               TID_EXE,
  output logic [WIDTH-1:0]   imem_addr,
  input  logic [WIDTH-1:0]   imem_rdata,
  input  tid_t               ID_TID,
  input  logic               ID_ready,
  output logic               ID_valid,
  output logic [WIDTH-1:0]   ID_instr,
  output logic [WIDTH-1:0]   ID_pc,
  output logic [THREADS-1:0] fetch_stall
);

  localparam int DEPTH = FQ_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int OW    = CW + 1;

  logic             r_f2_v;
  logic [WIDTH-1:0] r_f2_pc;
  tid_t             r_f2_tid;

  logic [THREADS-1:0] w_flush;
  logic [THREADS-1:0] w_f2_hit;
  logic [THREADS-1:0] w_push;
  logic [THREADS-1:0] w_pop;
  logic [CW-1:0]      w_count [THREADS];
  fq_entry_t          w_head  [THREADS];
  fq_entry_t          w_push_data;
  fq_entry_t          w_head_sel;
  logic               w_fire;

  assign imem_addr   = PCF;
  assign w_push_data = {imem_rdata, r_f2_pc};

  // Stall counts the word still in flight in F2, so a push can never overflow.
  for (genvar t = 0; t < THREADS; t++) begin : g_thread
    assign w_flush[t]     = EXE_BR_TAKEN && (TID_EXE == tid_t'(t));
    assign w_f2_hit[t]    = r_f2_v && (r_f2_tid == tid_t'(t));
    assign w_push[t]      = w_f2_hit[t] && !w_flush[t];
    assign w_pop[t]       = w_fire && (ID_TID == tid_t'(t));
    assign fetch_stall[t] = (OW'(w_count[t]) + OW'(w_f2_hit[t])) >= OW'(DEPTH);

    thread_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[t]),
      .i_pop   (w_pop[t]),
      .i_flush (w_flush[t]),
      .i_data  (w_push_data),
      .o_count (w_count[t]),
      .o_head  (w_head[t])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_f2_v   <= 1'b0;
      r_f2_pc  <= '0;
      r_f2_tid <= '0;
    end else begin
      r_f2_v   <= !fetch_stall[TID_fetch] && !w_flush[TID_fetch];
      r_f2_pc  <= PCF;
      r_f2_tid <= TID_fetch;
    end
  end

  assign ID_valid   = (w_count[ID_TID] != '0) && !w_flush[ID_TID];
  assign w_fire     = ID_valid && ID_ready;
  assign w_head_sel = mux4(w_head[0], w_head[1], w_head[2], w_head[3], ID_TID);
  assign ID_instr   = w_head_sel.instr;
  assign ID_pc      = w_head_sel.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a random run, all checked
// against a queue-based model of the per-thread buffers.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] PCF = '0;
  logic [1:0]  TID_fetch = '0;
  logic        EXE_BR_TAKEN = 1'b0;
  logic [1:0]  TID_EXE = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic [1:0]  ID_TID = '0;
  logic        ID_ready = 1'b0;
  logic        ID_valid;
  logic [31:0] ID_instr;
  logic [31:0] ID_pc;
  logic [3:0]  fetch_stall;

  int checks = 0;
  int errors = 0;

  // Model: one queue of {instr,pc} per thread plus the word in flight.
  logic [63:0] mq [4][$];
  bit          mf2_v = 1'b0;
  logic [31:0] mf2_pc = '0;
  logic [1:0]  mf2_tid = '0;

  fetch_queue dut (
    .clk          (clk),
    .rst          (rst),
    .PCF          (PCF),
    .TID_fetch    (TID_fetch),
    .EXE_BR_TAKEN (EXE_BR_TAKEN),
    .TID_EXE      (TID_EXE),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .ID_TID       (ID_TID),
    .ID_ready     (ID_ready),
    .ID_valid     (ID_valid),
    .ID_instr     (ID_instr),
    .ID_pc        (ID_pc),
    .fetch_stall  (fetch_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  // Synchronous instruction memory: word valid one cycle after the address.
  always @(posedge clk) imem_rdata <= imem_word(imem_addr);

  function automatic logic [3:0] m_stall();
    logic [3:0] s;
    for (int t = 0; t < 4; t++)
      s[t] = (mq[t].size() + ((mf2_v && mf2_tid == 2'(t)) ? 1 : 0)) >= 2;
    return s;
  endfunction

  function automatic bit m_valid();
    return (mq[ID_TID].size() != 0) && !(EXE_BR_TAKEN && TID_EXE == ID_TID);
  endfunction

  function automatic logic [63:0] m_head();
    return (mq[ID_TID].size() != 0) ? mq[ID_TID][0] : 64'd0;
  endfunction

  task automatic drive(input logic [31:0] pc, input logic [1:0] tf, input logic br,
                       input logic [1:0] te, input logic [1:0] it, input logic rdy);
    PCF = pc; TID_fetch = tf; EXE_BR_TAKEN = br; TID_EXE = te; ID_TID = it; ID_ready = rdy;
  endtask

  task automatic tick();
    logic [3:0] st;
    bit         v;
    st = m_stall();
    v  = m_valid();
    @(posedge clk);
    if (EXE_BR_TAKEN) mq[TID_EXE].delete();
    if (v && ID_ready) void'(mq[ID_TID].pop_front());
    if (mf2_v && !(EXE_BR_TAKEN && TID_EXE == mf2_tid))
      mq[mf2_tid].push_back({imem_word(mf2_pc), mf2_pc});
    mf2_v   = !st[TID_fetch] && !(EXE_BR_TAKEN && TID_EXE == TID_fetch);
    mf2_pc  = PCF;
    mf2_tid = TID_fetch;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int t = 0; t < 4; t++) mq[t].delete();
    mf2_v = 1'b0;
    drive(32'h0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (ID_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", ID_valid); end
    checks++; if (fetch_stall !== 4'h0) begin errors++; $display("[TB] FAIL reset_stall got %h exp 0", fetch_stall); end
    checks++; if ({ID_instr, ID_pc} !== 64'h0) begin errors++; $display("[TB] FAIL reset_head got %h exp 0", {ID_instr, ID_pc}); end
    do_reset();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(32'(4 * c), 2'(c), 1'b0, 2'd0, 2'd2, 1'b0);
      @(negedge clk);
      checks++; if (imem_addr !== 32'(4 * c)) begin errors++; $display("[TB] FAIL rr_addr got %h exp %h", imem_addr, 32'(4 * c)); end
      tick();
    end
    drive(32'h10, 2'd0, 1'b0, 2'd0, 2'd2, 1'b0);
    @(negedge clk);
    checks++; if ({ID_valid, ID_pc, ID_instr} !== {1'b1, 32'h8, imem_word(32'h8)}) begin
      errors++; $display("[TB] FAIL rr_t2_head got %b/%h/%h exp 1/8/%h", ID_valid, ID_pc, ID_instr, imem_word(32'h8));
    end
    tick();
    for (int t = 0; t < 4; t++) begin
      drive(32'h20 + 32'(4 * t), 2'((t + 3) % 4), 1'b0, 2'd0, 2'(t), 1'b0);
      @(negedge clk);
      checks++; if ({ID_valid, ID_pc, ID_instr} !== {1'b1, 32'(4 * t), imem_word(32'(4 * t))}) begin
        errors++; $display("[TB] FAIL rr_head_t%0d got %b/%h exp 1/%h", t, ID_valid, ID_pc, 32'(4 * t));
      end
      tick();
    end
  endtask

  task automatic test_fill_stall();
    logic [3:0] exp_st [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(32'h100 + 32'(4 * c), 2'd1, 1'b0, 2'd0, 2'd1, (c == 4));
      @(negedge clk);
      checks++; if (fetch_stall[1] !== exp_st[c][0]) begin
        errors++; $display("[TB] FAIL fill_stall_c%0d got %b exp %b", c, fetch_stall[1], exp_st[c][0]);
      end
      if (c == 3) begin
        checks++; if ({ID_valid, ID_pc} !== {1'b1, 32'h100}) begin errors++; $display("[TB] FAIL fill_head got %b/%h exp 1/100", ID_valid, ID_pc); end
      end
      if (c == 5) begin
        checks++; if ({ID_valid, ID_pc} !== {1'b1, 32'h104}) begin errors++; $display("[TB] FAIL fill_after_pop got %b/%h exp 1/104", ID_valid, ID_pc); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [31:0] pcs [5] = '{32'h10, 32'h20, 32'h30, 32'h300, 32'h304};
    logic [1:0]  tfs [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      drive(pcs[c], tfs[c], 1'b0, 2'd0, 2'd0, 1'b0);
      @(negedge clk);
      tick();
    end
    drive(32'h14, 2'd0, 1'b1, 2'd3, 2'd3, 1'b0);
    @(negedge clk);
    checks++; if ({ID_valid, fetch_stall[3]} !== 2'b01) begin errors++; $display("[TB] FAIL flush_cycle got %b%b exp 01", ID_valid, fetch_stall[3]); end
    tick();
    drive(32'h400, 2'd3, 1'b0, 2'd0, 2'd3, 1'b0);
    @(negedge clk);
    checks++; if ({ID_valid, fetch_stall[3]} !== 2'b00) begin errors++; $display("[TB] FAIL flush_after got %b%b exp 00", ID_valid, fetch_stall[3]); end
    tick();
    for (int t = 0; t < 3; t++) begin
      drive(32'h404 + 32'(4 * t), 2'd3, 1'b0, 2'd0, 2'(t), 1'b0);
      @(negedge clk);
      checks++; if ({ID_valid, ID_pc} !== {1'b1, 32'h10 * 32'(t + 1)}) begin
        errors++; $display("[TB] FAIL flush_other_t%0d got %b/%h exp 1/%h", t, ID_valid, ID_pc, 32'h10 * 32'(t + 1));
      end
      tick();
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    drive(32'h500, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0); @(negedge clk); tick();
    drive(32'h504, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0); @(negedge clk); tick();
    drive(32'h600, 2'd1, 1'b0, 2'd0, 2'd0, 1'b1);
    @(negedge clk);
    checks++; if ({ID_valid, ID_pc, fetch_stall[0]} !== {1'b1, 32'h500, 1'b1}) begin
      errors++; $display("[TB] FAIL pp_before got %b/%h/%b exp 1/500/1", ID_valid, ID_pc, fetch_stall[0]);
    end
    tick();
    drive(32'h604, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    checks++; if ({ID_valid, ID_pc, fetch_stall[0]} !== {1'b1, 32'h504, 1'b0}) begin
      errors++; $display("[TB] FAIL pp_after got %b/%h/%b exp 1/504/0", ID_valid, ID_pc, fetch_stall[0]);
    end
    tick();
  endtask

  task automatic test_flush_pop();
    do_reset();
    drive(32'h600, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0); @(negedge clk); tick();
    drive(32'h700, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0); @(negedge clk); tick();
    drive(32'h710, 2'd3, 1'b0, 2'd0, 2'd0, 1'b0); @(negedge clk); tick();
    drive(32'h720, 2'd3, 1'b1, 2'd2, 2'd2, 1'b1);
    @(negedge clk);
    checks++; if (ID_valid !== 1'b0) begin errors++; $display("[TB] FAIL fp_valid got %b exp 0", ID_valid); end
    tick();
    drive(32'h730, 2'd0, 1'b0, 2'd0, 2'd1, 1'b0);
    @(negedge clk);
    checks++; if ({ID_valid, ID_pc} !== {1'b1, 32'h700}) begin errors++; $display("[TB] FAIL fp_t1 got %b/%h exp 1/700", ID_valid, ID_pc); end
    tick();
    drive(32'h734, 2'd0, 1'b0, 2'd0, 2'd2, 1'b0);
    @(negedge clk);
    checks++; if (ID_valid !== 1'b0) begin errors++; $display("[TB] FAIL fp_t2_empty got %b exp 0", ID_valid); end
    tick();
  endtask

  task automatic test_random();
    logic [63:0] eh;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive($urandom & 32'h0000_FFFC, 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      eh = m_head();
      checks++; if (fetch_stall !== m_stall()) begin errors++; $display("[TB] FAIL rnd_stall c%0d got %h exp %h", c, fetch_stall, m_stall()); end
      checks++; if (ID_valid !== m_valid()) begin errors++; $display("[TB] FAIL rnd_valid c%0d got %b exp %b", c, ID_valid, m_valid()); end
      checks++; if ({ID_instr, ID_pc} !== eh) begin errors++; $display("[TB] FAIL rnd_head c%0d got %h exp %h", c, {ID_instr, ID_pc}, eh); end
      checks++; if (imem_addr !== PCF) begin errors++; $display("[TB] FAIL rnd_addr c%0d got %h exp %h", c, imem_addr, PCF); end
      tick();
    end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    drive(32'h800, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0); @(negedge clk); tick();
    drive(32'h804, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0); @(negedge clk); tick();
    drive(32'h808, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk);
    checks++; if ({ID_valid, fetch_stall[0]} !== 2'b11) begin errors++; $display("[TB] FAIL mr_before got %b%b exp 11", ID_valid, fetch_stall[0]); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({ID_valid, fetch_stall, ID_pc} !== {1'b0, 4'h0, 32'h0}) begin
      errors++; $display("[TB] FAIL mr_async got %b/%h/%h exp 0/0/0", ID_valid, fetch_stall, ID_pc);
    end
    for (int t = 0; t < 4; t++) mq[t].delete();
    mf2_v = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(32'h900, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0);
    #1;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      checks++; if ({ID_valid, fetch_stall} !== {1'b0, m_stall()}) begin
        errors++; $display("[TB] FAIL mr_after_c%0d got %b/%h exp 0/%h", c, ID_valid, fetch_stall, m_stall());
      end
      tick();
    end
  endtask

  // Scenario sequence followed by the one-line summary.
  initial begin
    test_reset();
    test_round_robin();
    test_fill_stall();
    test_flush();
    test_push_pop();
    test_flush_pop();
    test_random();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
